// File: rtl/goertzel_core_if.sv
// Sample-in / power-out handshake bundle for goertzel_core.
// The master is the sample source and result consumer; the core uses the slave modport.
interface goertzel_core_if #(
    parameter int unsigned DW = 32
) ();
    logic [DW-1:0]   coef_in;
    logic            s_valid_in;
    logic            s_ready_out;
    logic [DW-1:0]   s_data_in;
    logic            m_valid_out;
    logic            m_ready_in;
    logic [2*DW-1:0] m_power_out;
    logic            ovf_out;

    modport master (
        output coef_in, s_valid_in, s_data_in, m_ready_in,
        input  s_ready_out, m_valid_out, m_power_out, ovf_out
    );

    modport slave (
        input  coef_in, s_valid_in, s_data_in, m_ready_in,
        output s_ready_out, m_valid_out, m_power_out, ovf_out
    );
endinterface

// File: rtl/goertzel_core.sv
// Single-bin Goertzel engine: N-sample recursion, then bin power through one shared multiplier.
// Define GOERTZEL_SAT_EN for saturating state arithmetic with a sticky overflow flag.
module goertzel_core #(
    parameter int unsigned DW    = 32,
    parameter int unsigned INT_S = 16,
    parameter int unsigned INT_C = 2,
    parameter int unsigned N     = 205
) (
    input logic            clk_in,
    input logic            rst_in,
    goertzel_core_if.slave bus
);
    localparam int unsigned FRQ_C = DW - INT_C;
    localparam int unsigned WW    = 2 * DW + 2;
    localparam int unsigned CW    = $clog2(N + 1);

    localparam logic signed [WW-1:0] PW_MAX = {3'b000, {(2*DW-1){1'b1}}};
`ifdef GOERTZEL_SAT_EN
    localparam logic signed [WW-1:0] SAT_MAX = {{(WW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [WW-1:0] SAT_MIN = ~SAT_MAX;
`endif

    if (N < 2 || INT_S > DW || INT_C > DW) begin : g_bad_param
        $error("goertzel_core: illegal parameter combination");
    end

    typedef enum logic [2:0] {StIdle, StAcc, StFin1, StFin2, StFin3, StFin4, StDone} state_t;

    function automatic logic signed [WW-1:0] sx(input logic signed [DW-1:0] v);
        return {{(WW-DW){v[DW-1]}}, v};
    endfunction

    function automatic logic signed [DW-1:0] fit(input logic signed [WW-1:0] v);
`ifdef GOERTZEL_SAT_EN
        if (v > SAT_MAX)      return {1'b0, {(DW-1){1'b1}}};
        else if (v < SAT_MIN) return {1'b1, {(DW-1){1'b0}}};
        else                  return v[DW-1:0];
`else
        return v[DW-1:0];
`endif
    endfunction

`ifdef GOERTZEL_SAT_EN
    function automatic logic sat_hit(input logic signed [WW-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction
`endif

    state_t                 r_state;
    logic signed [DW-1:0]   r_coef, r_s1, r_s2, r_t;
    logic signed [2*DW-1:0] r_p0, r_p1, r_p2;
    logic [2*DW-1:0]        r_power;
    logic [CW-1:0]          r_cnt;
    logic                   r_s_ready, r_m_valid;
`ifdef GOERTZEL_SAT_EN
    logic                   r_ovf;
`endif

    logic signed [DW-1:0]   w_mul_a, w_mul_b, w_m, w_snew;
    logic signed [2*DW-1:0] w_prod;
    logic signed [WW-1:0]   w_scaled, w_snew_x, w_pw_x;
    logic [2*DW-1:0]        w_power;
    logic                   w_accept;

    // One multiplier: coef*s1 while accumulating and in FIN3, squares/cross term otherwise.
    always_comb begin
        w_mul_a = r_coef;
        w_mul_b = r_s1;
        unique case (r_state)
            StFin1:  begin w_mul_a = r_s1; w_mul_b = r_s1; end
            StFin2:  begin w_mul_a = r_s2; w_mul_b = r_s2; end
            StFin4:  begin w_mul_a = r_t;  w_mul_b = r_s2; end
            default: ;
        endcase
    end

    assign w_prod   = w_mul_a * w_mul_b;
    assign w_scaled = {{2{w_prod[2*DW-1]}}, w_prod} >>> FRQ_C;
    assign w_m      = fit(w_scaled);
    assign w_snew_x = sx($signed(bus.s_data_in)) + sx(w_m) - sx(r_s2);
    assign w_snew   = fit(w_snew_x);
    assign w_accept = r_s_ready & bus.s_valid_in;

    assign w_pw_x = {{2{r_p0[2*DW-1]}}, r_p0} + {{2{r_p1[2*DW-1]}}, r_p1}
                  - {{2{r_p2[2*DW-1]}}, r_p2};

    always_comb begin
        w_power = w_pw_x[2*DW-1:0];
        if (w_pw_x[WW-1])         w_power = '0;
        else if (w_pw_x > PW_MAX) w_power = PW_MAX[2*DW-1:0];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= StIdle;
            r_coef    <= '0;
            r_s1      <= '0;
            r_s2      <= '0;
            r_t       <= '0;
            r_p0      <= '0;
            r_p1      <= '0;
            r_p2      <= '0;
            r_power   <= '0;
            r_cnt     <= '0;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
`ifdef GOERTZEL_SAT_EN
            r_ovf     <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                StIdle, StAcc: begin
                    r_s_ready <= 1'b1;
                    if (w_accept) begin
                        if (r_state == StIdle) r_coef <= $signed(bus.coef_in);
                        r_s2  <= r_s1;
                        r_s1  <= w_snew;
                        r_cnt <= r_cnt + 1'b1;
`ifdef GOERTZEL_SAT_EN
                        r_ovf <= r_ovf | sat_hit(w_scaled) | sat_hit(w_snew_x);
`endif
                        if (r_cnt == CW'(N - 1)) begin
                            r_state   <= StFin1;
                            r_s_ready <= 1'b0;
                        end else begin
                            r_state   <= StAcc;
                        end
                    end
                end
                StFin1: begin
                    r_p0    <= w_prod;
                    r_state <= StFin2;
                end
                StFin2: begin
                    r_p1    <= w_prod;
                    r_state <= StFin3;
                end
                StFin3: begin
                    r_t     <= w_m;
`ifdef GOERTZEL_SAT_EN
                    r_ovf   <= r_ovf | sat_hit(w_scaled);
`endif
                    r_state <= StFin4;
                end
                StFin4: begin
                    r_p2    <= w_prod;
                    r_state <= StDone;
                end
                StDone: begin
                    // First DONE cycle registers the power; afterwards wait for the handshake.
                    if (!r_m_valid) begin
                        r_power   <= w_power;
                        r_m_valid <= 1'b1;
                    end else if (bus.m_ready_in) begin
                        r_m_valid <= 1'b0;
                        r_s1      <= '0;
                        r_s2      <= '0;
                        r_cnt     <= '0;
                        r_s_ready <= 1'b1;
                        r_state   <= StIdle;
`ifdef GOERTZEL_SAT_EN
                        r_ovf     <= 1'b0;
`endif
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.s_ready_out = r_s_ready;
    assign bus.m_valid_out = r_m_valid;
    assign bus.m_power_out = r_power;
`ifdef GOERTZEL_SAT_EN
    assign bus.ovf_out     = r_ovf;
`else
    assign bus.ovf_out     = 1'b0;
`endif
endmodule

// File: tb/tb_goertzel_core.sv
// Directed bench for goertzel_core with N=4: table of blocks plus reset/backpressure sequences.
// Overflow expectations follow GOERTZEL_SAT_EN.
module tb_goertzel_core;
    localparam int unsigned DW = 32;
    localparam int unsigned NS = 4;

    localparam logic [DW-1:0] ONE = 32'h0001_0000;
    localparam logic [DW-1:0] C1  = 32'h4000_0000;
    localparam logic [DW-1:0] BIG = 32'h7FFF_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    goertzel_core_if #(.DW(DW)) bus ();

    goertzel_core #(
        .DW   (DW),
        .INT_S(16),
        .INT_C(2),
        .N    (NS)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0]          coef;
        logic [NS-1:0][DW-1:0]  x;
        bit                     coef_chg;
        bit                     bp;
        logic [2*DW-1:0]        pw;
        logic                   ovf;
    } vec_t;

    vec_t vecs[4];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        for (int i = 0; i < NS; i++) begin
            @(negedge clk);
            check($sformatf("v%0d ready_acc%0d", idx, i), 64'(bus.s_ready_out), 64'd1);
            bus.s_valid_in = 1'b1;
            bus.s_data_in  = v.x[i];
            bus.coef_in    = (i > 0 && v.coef_chg) ? '0 : v.coef;
        end
        @(negedge clk);
        bus.s_valid_in = v.bp;
        check($sformatf("v%0d ready_drop", idx), 64'(bus.s_ready_out), 64'd0);
        lat = 0;
        while (!bus.m_valid_out && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d latency", idx), 64'(lat), 64'd5);
        check($sformatf("v%0d power", idx), bus.m_power_out, v.pw);
        check($sformatf("v%0d ovf", idx), 64'(bus.ovf_out), 64'(v.ovf));
        if (v.bp) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                check($sformatf("v%0d bp_ready%0d", idx, c), 64'(bus.s_ready_out), 64'd0);
                check($sformatf("v%0d bp_valid%0d", idx, c), 64'(bus.m_valid_out), 64'd1);
            end
            check($sformatf("v%0d bp_power", idx), bus.m_power_out, v.pw);
        end
        bus.m_ready_in = 1'b1;
        @(negedge clk);
        bus.m_ready_in = 1'b0;
        bus.s_valid_in = 1'b0;
        check($sformatf("v%0d hs_valid", idx), 64'(bus.m_valid_out), 64'd0);
        check($sformatf("v%0d hs_ready", idx), 64'(bus.s_ready_out), 64'd1);
    endtask

    initial begin
        bus.coef_in    = '0;
        bus.s_valid_in = 1'b0;
        bus.s_data_in  = '0;
        bus.m_ready_in = 1'b0;

        for (int k = 0; k < 4; k++) begin
            vecs[k].coef     = C1;
            vecs[k].coef_chg = 1'b0;
            vecs[k].bp       = 1'b0;
            vecs[k].ovf      = 1'b0;
            vecs[k].pw       = 64'h0000_0003_0000_0000;
            for (int i = 0; i < NS; i++) vecs[k].x[i] = ONE;
        end
        // Impulse with coef=0: s1=0, s2=-1.0, power 1.0.
        vecs[0].coef = '0;
        for (int i = 1; i < NS; i++) vecs[0].x[i] = '0;
        vecs[0].pw   = 64'h0000_0001_0000_0000;
        vecs[2].coef_chg = 1'b1;
        vecs[2].bp       = 1'b1;
        for (int i = 0; i < NS; i++) vecs[3].x[i] = BIG;
`ifdef GOERTZEL_SAT_EN
        vecs[3].pw  = 64'h3FFF_8000_7FFF_0001;
        vecs[3].ovf = 1'b1;
`else
        vecs[3].pw  = 64'h4000_0003_0000_0000;
        vecs[3].ovf = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("rst s_ready", 64'(bus.s_ready_out), 64'd0);
        check("rst m_valid", 64'(bus.m_valid_out), 64'd0);
        check("rst power", bus.m_power_out, 64'd0);
        check("rst ovf", 64'(bus.ovf_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst s_ready", 64'(bus.s_ready_out), 64'd1);

        for (int k = 0; k < 4; k++) run_vec(vecs[k], k);

        // Abort a partial block with a one-cycle reset; the next block must be clean.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.s_valid_in = 1'b1;
            bus.s_data_in  = ONE;
            bus.coef_in    = C1;
        end
        @(negedge clk);
        bus.s_valid_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort s_ready", 64'(bus.s_ready_out), 64'd0);
        check("abort m_valid", 64'(bus.m_valid_out), 64'd0);
        check("abort power", bus.m_power_out, 64'd0);
        check("abort ovf", 64'(bus.ovf_out), 64'd0);
        @(negedge clk);
        check("abort ready_back", 64'(bus.s_ready_out), 64'd1);
        run_vec(vecs[1], 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/goertzel_core.md
# goertzel_core

Goertzel recursion engine for single-bin tone detection. Accepts a stream of fixed-point samples over a valid/ready handshake and runs s[n] = x[n] + coef·s[n-1] − s[n-2] for N samples. It then computes the bin power s1² + s2² − coef·s1·s2 and presents it on a valid/ready output. It sits between the sample source (decimator/ADC interface) and the threshold/decision logic, and is the consumer of the team's signed fixed-point multiply arithmetic.

## Interface
- DW, 32, data width of samples, state and coefficient
- INT_S, 16, integer bits of sample/state format (INT_S.DW-INT_S)
- INT_C, 2, integer bits of coefficient format (INT_C.DW-INT_C)
- N, 205, samples per block (N ≥ 2)

- clk_in  in  1  clock, rising edge
- rst_in  in  1  reset: synchronous, active-high
- coef_in  in  DW  2·cos(ω), signed INT_C.FRQ_C
- s_valid_in  in  1  sample valid
- s_ready_out  out  1  sample ready
- s_data_in  in  DW  sample x[n], signed INT_S.FRQ_S
- m_valid_out  out  1  result valid
- m_ready_in  in  1  result accepted
- m_power_out  out  2·DW  bin power, signed 2·INT_S.2·FRQ_S
- ovf_out  out  1  state overflow occurred in this block (qualified by m_valid_out)

## Operation
- States: IDLE, ACC, FIN1, FIN2, FIN3, FIN4, DONE.
- IDLE/ACC: s_ready_out=1. Accept on s_valid_in & s_ready_out.
- First accepted sample of a block latches coef_in into coef_r. coef_in changes later in the block are ignored.
- Per accepted sample:
  - m = (coef_r·s1) arithmetic-shifted right by FRQ_C (floor), then fit to DW.
  - s_new = x + m − s2, computed in DW+2 bits, then fit to DW.
  - Update s2←s1, s1←s_new, cnt←cnt+1.
- IDLE→ACC on the first accept. ACC→FIN1 on the accept that makes cnt=N.
- The final phase uses one multiplier time-multiplexed:
  - FIN1: p0=s1·s1
  - FIN2: p1=s2·s2
  - FIN3: t=fit(coef_r·s1>>FRQ_C)
  - FIN4: p2=t·s2
  - Then power = p0+p1−p2 in 2·DW+2 bits. Clamp <0 to 0 and >2^(2DW−1)−1 to max. Register it, go to DONE.
- DONE: m_valid_out=1, s_ready_out=0. m_power_out and ovf_out are held stable until m_ready_in.
- On the DONE handshake: s1=s2=0, cnt=0, ovf flag cleared, go to IDLE.
- "fit" is as selected by the configuration macro.

## Timing
- Reset values: s_ready_out=0, m_valid_out=0, m_power_out=0, ovf_out=0, s1=s2=cnt=0. State IDLE; s_ready_out=1 in the first cycle after rst_in deasserts.
- Throughput in ACC: one sample per clock.
- Latency: m_valid_out rises on the 5th rising edge after the edge accepting sample N. The 4 FIN cycles plus the DONE register.
- s_ready_out drops in the cycle after the last accept and stays low through FIN1–FIN4 and DONE.
- The DONE handshake edge clears m_valid_out, and s_ready_out=1 in the following cycle. No sample is accepted on the handshake edge.
- rst_in wins over all other events, in any state. A partial block or pending result is discarded; no output is produced.
- cnt wraps to 0 only via the DONE handshake or reset.

## Configuration
- GOERTZEL_SAT_EN defined:
  - fit saturates to [−2^(DW−1), 2^(DW−1)−1].
  - Any saturation of m, s_new or t sets a sticky flag, reported on ovf_out with the result.
- Undefined:
  - fit keeps the low DW bits (two's-complement wrap).
  - ovf_out tied to 0.

## Test plan
- N=4, coef=0, x=1.0,0,0,0 (0x00010000, 0, 0, 0) -> s1=0, s2=−1.0; m_power_out=0x0000_0001_0000_0000; ovf_out=0; valid 5 edges after the 4th accept.
- N=4, coef=1.0 (0x40000000), x=1.0 ×4 -> s sequence 1, 2, 2, 1; m_power_out=3·2^32.
- Same as previous, but coef_in driven to 0 after the first accept -> result still 3·2^32.
- Backpressure: hold m_ready_in=0 for 10 cycles with s_valid_in=1 -> m_power_out stable, s_ready_out=0, no sample consumed. After the handshake, s_ready_out=1 the next cycle.
- Overflow: coef=1.0, x=0x7FFF0000 ×4.
  - With GOERTZEL_SAT_EN: state clamps at 0x7FFFFFFF, ovf_out=1.
  - Without it: state wraps, ovf_out=0.
- rst_in pulsed for 1 cycle after 2 accepted samples -> all outputs 0. The next 4-sample block of the coef=1.0, x=1.0 case yields 3·2^32 with no residue.
